// File: rtl/mem_arbiter.sv
// -----------------------------------------------------------------------------
// mem_arbiter
//   Two-master to one-slave pipelined Wishbone arbiter. Master 0 is the
//   instruction fetch module (read-only), master 1 is the load/store module.
//   One master owns the bus for a whole cycle. The arbiter counts outstanding
//   requests, and after the owner aborts a cycle it absorbs the stale acks so
//   that they never reach either master.
//
// Configuration macro:
//   ARB_ROUND_ROBIN_EN  defined   : ties in IDLE go to the master not granted
//                                   last time (last-owner flag resets to m0)
//                       undefined : fixed priority, m1 (LSM) wins ties
//
// Parameters:
//   OUTSTANDING_W  width of the outstanding-request counter (max 2^W-1)
//
// Ports:
//   clk_i, rst_i               clock, asynchronous active-low reset
//   m0_adr_i/sel_i/stb_i/cyc_i IFM request (no write path)
//   m1_adr_i/dat_i/sel_i/we_i/stb_i/cyc_i  LSM request
//   m0_dat_o, m1_dat_o         slave read data, broadcast to both masters
//   m0_ack_o, m1_ack_o         ack, routed to the current owner only
//   m0_stall_o, m1_stall_o     stall, held at 1 for a non-owner
//   wb_*_o / wb_*_i            slave-side Wishbone bus
//   busy_o                     arbiter is not IDLE
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned OUTSTANDING_W = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,

    input  logic [31:0] m0_adr_i,
    output logic [31:0] m0_dat_o,
    input  logic [3:0]  m0_sel_i,
    input  logic        m0_stb_i,
    input  logic        m0_cyc_i,
    output logic        m0_ack_o,
    output logic        m0_stall_o,

    input  logic [31:0] m1_adr_i,
    output logic [31:0] m1_dat_o,
    input  logic [31:0] m1_dat_i,
    input  logic [3:0]  m1_sel_i,
    input  logic        m1_we_i,
    input  logic        m1_stb_i,
    input  logic        m1_cyc_i,
    output logic        m1_ack_o,
    output logic        m1_stall_o,

    output logic [31:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    output logic [3:0]  wb_sel_o,
    output logic        wb_we_o,
    output logic        wb_stb_o,
    output logic        wb_cyc_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    input  logic        wb_stall_i,

    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        OWN_M0 = 2'd1,
        OWN_M1 = 2'd2,
        DRAIN  = 2'd3
    } state_t;

    localparam logic [OUTSTANDING_W-1:0] CNT_ONE = OUTSTANDING_W'(1);

    state_t                   r_state;
    state_t                   w_next;
    logic [OUTSTANDING_W-1:0] r_cnt;

    logic                     w_full;
    logic                     w_tie_m1;
    logic                     w_inc;
    logic                     w_dec;

    logic [31:0]              w_adr;
    logic [31:0]              w_dat;
    logic [3:0]               w_sel;
    logic                     w_we;
    logic                     w_stb;
    logic                     w_cyc;
    logic                     w_m0_ack;
    logic                     w_m1_ack;
    logic                     w_m0_stall;
    logic                     w_m1_stall;

    assign w_full = (r_cnt == '1);

`ifdef ARB_ROUND_ROBIN_EN
    // 1 when m1 was the most recent grant; resets to m0 so m1 wins the first tie
    logic r_last_m1;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_last_m1 <= 1'b0;
        end else if (r_state == IDLE && w_next != IDLE) begin
            r_last_m1 <= (w_next == OWN_M1);
        end
    end

    assign w_tie_m1 = !r_last_m1;
`else
    assign w_tie_m1 = 1'b1;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and bus muxing
    // ------------------------------------------------------------------
    always_comb begin
        w_next     = r_state;
        w_adr      = '0;
        w_dat      = '0;
        w_sel      = '0;
        w_we       = 1'b0;
        w_stb      = 1'b0;
        w_cyc      = 1'b0;
        w_m0_ack   = 1'b0;
        w_m1_ack   = 1'b0;
        w_m0_stall = 1'b1;
        w_m1_stall = 1'b1;

        case (r_state)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    w_next = w_tie_m1 ? OWN_M1 : OWN_M0;
                end else if (m1_cyc_i) begin
                    w_next = OWN_M1;
                end else if (m0_cyc_i) begin
                    w_next = OWN_M0;
                end
            end

            OWN_M0: begin
                w_adr      = m0_adr_i;
                w_sel      = m0_sel_i;
                w_cyc      = m0_cyc_i;
                // strobe is qualified by cyc so a dropped cycle never counts
                w_stb      = m0_stb_i && m0_cyc_i && !w_full;
                w_m0_stall = wb_stall_i || w_full;
                w_m0_ack   = wb_ack_i;
                if (!m0_cyc_i) begin
                    w_next = (r_cnt == '0) ? IDLE : DRAIN;
                end
            end

            OWN_M1: begin
                w_adr      = m1_adr_i;
                w_dat      = m1_dat_i;
                w_sel      = m1_sel_i;
                w_we       = m1_we_i;
                w_cyc      = m1_cyc_i;
                w_stb      = m1_stb_i && m1_cyc_i && !w_full;
                w_m1_stall = wb_stall_i || w_full;
                w_m1_ack   = wb_ack_i;
                if (!m1_cyc_i) begin
                    w_next = (r_cnt == '0) ? IDLE : DRAIN;
                end
            end

            DRAIN: begin
                // keep the cycle open while the slave returns stale acks
                w_cyc = 1'b1;
                if (r_cnt == '0 || (r_cnt == CNT_ONE && wb_ack_i)) begin
                    w_next = IDLE;
                end
            end

            default: begin
                w_next = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outstanding-request counter
    // ------------------------------------------------------------------
    assign w_inc = w_stb && !wb_stall_i;
    // acks in IDLE or with nothing outstanding are ignored (no underflow)
    assign w_dec = wb_ack_i && (r_cnt != '0) && (r_state != IDLE);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_cnt <= '0;
        end else begin
            case ({w_inc, w_dec})
                2'b10: if (!w_full) r_cnt <= r_cnt + CNT_ONE;
                2'b01: r_cnt <= r_cnt - CNT_ONE;
                default: r_cnt <= r_cnt;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign wb_adr_o   = w_adr;
    assign wb_dat_o   = w_dat;
    assign wb_sel_o   = w_sel;
    assign wb_we_o    = w_we;
    assign wb_stb_o   = w_stb;
    assign wb_cyc_o   = w_cyc;

    assign m0_ack_o   = w_m0_ack;
    assign m1_ack_o   = w_m1_ack;
    assign m0_stall_o = w_m0_stall;
    assign m1_stall_o = w_m1_stall;

    assign m0_dat_o   = wb_dat_i;
    assign m1_dat_o   = wb_dat_i;

    assign busy_o     = (r_state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_arbiter
//   Directed bench for mem_arbiter. Two instances share all inputs: "dut" with
//   the default counter width, "dut_sat" with OUTSTANDING_W=2 for saturation.
//   Inputs change 1 ns after the rising edge; outputs are sampled 2 ns later.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] m0_adr, m1_adr, m1_dat, wb_dat_i;
    logic [3:0]  m0_sel, m1_sel;
    logic        m1_we, m0_stb, m1_stb, m0_cyc, m1_cyc;
    logic        wb_ack, wb_stall;

    logic [31:0] o_m0_dat, o_m1_dat, o_wb_adr, o_wb_dat;
    logic [3:0]  o_wb_sel;
    logic        o_m0_ack, o_m1_ack, o_m0_stall, o_m1_stall;
    logic        o_wb_we, o_wb_stb, o_wb_cyc, o_busy;

    logic [31:0] s_m0_dat, s_m1_dat, s_wb_adr, s_wb_dat;
    logic [3:0]  s_wb_sel;
    logic        s_m0_ack, s_m1_ack, s_m0_stall, s_m1_stall;
    logic        s_wb_we, s_wb_stb, s_wb_cyc, s_busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_o(o_m0_dat), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(o_m0_ack),
        .m0_stall_o(o_m0_stall),
        .m1_adr_i(m1_adr), .m1_dat_o(o_m1_dat), .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_stb_i(m1_stb),
        .m1_cyc_i(m1_cyc), .m1_ack_o(o_m1_ack), .m1_stall_o(o_m1_stall),
        .wb_adr_o(o_wb_adr), .wb_dat_o(o_wb_dat), .wb_sel_o(o_wb_sel),
        .wb_we_o(o_wb_we), .wb_stb_o(o_wb_stb), .wb_cyc_o(o_wb_cyc),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_stall_i(wb_stall),
        .busy_o(o_busy)
    );

    mem_arbiter #(.OUTSTANDING_W(2)) dut_sat (
        .clk_i(clk), .rst_i(rst_n),
        .m0_adr_i(m0_adr), .m0_dat_o(s_m0_dat), .m0_sel_i(m0_sel),
        .m0_stb_i(m0_stb), .m0_cyc_i(m0_cyc), .m0_ack_o(s_m0_ack),
        .m0_stall_o(s_m0_stall),
        .m1_adr_i(m1_adr), .m1_dat_o(s_m1_dat), .m1_dat_i(m1_dat),
        .m1_sel_i(m1_sel), .m1_we_i(m1_we), .m1_stb_i(m1_stb),
        .m1_cyc_i(m1_cyc), .m1_ack_o(s_m1_ack), .m1_stall_o(s_m1_stall),
        .wb_adr_o(s_wb_adr), .wb_dat_o(s_wb_dat), .wb_sel_o(s_wb_sel),
        .wb_we_o(s_wb_we), .wb_stb_o(s_wb_stb), .wb_cyc_o(s_wb_cyc),
        .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack), .wb_stall_i(wb_stall),
        .busy_o(s_busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        logic [75:0] obs;
        rst_n = 1'b0;
        m0_adr = '0; m1_adr = '0; m1_dat = '0; wb_dat_i = '0;
        m0_sel = '0; m1_sel = '0; m1_we = 1'b0;
        m0_stb = 1'b0; m1_stb = 1'b0; m0_cyc = 1'b1; m1_cyc = 1'b0;
        wb_ack = 1'b0; wb_stall = 1'b0;
        step(); step();
        settle();
        obs = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
               o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack, o_busy};
        n_cmp++;
        if (obs !== {3'b000, 32'h0, 4'h0, 32'h0, 2'b11, 3'b000}) begin
            n_err++;
            $display("FAIL reset_outputs got=%h exp=%h", obs,
                     {3'b000, 32'h0, 4'h0, 32'h0, 2'b11, 3'b000});
        end
        m0_cyc = 1'b0;
        rst_n  = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_m0_read();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h100; m0_sel = 4'hF;
        settle();
        n_cmp++;
        if ({o_m0_stall, o_wb_stb, o_busy} !== 3'b100) begin
            n_err++;
            $display("FAIL m0rd_grant_latency got=%b exp=100",
                     {o_m0_stall, o_wb_stb, o_busy});
        end
        step(); settle();
        n_cmp++;
        if ({o_wb_adr, o_wb_stb, o_wb_cyc, o_wb_we, o_m0_stall, o_m1_stall, o_busy}
            !== {32'h100, 6'b110011}) begin
            n_err++;
            $display("FAIL m0rd_owned got=%h exp=%h",
                     {o_wb_adr, o_wb_stb, o_wb_cyc, o_wb_we, o_m0_stall, o_m1_stall, o_busy},
                     {32'h100, 6'b110011});
        end
        step();
        m0_stb = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'hDEADBEEF;
        settle();
        n_cmp++;
        if ({o_m0_ack, o_m0_dat, o_m1_ack, o_m1_stall, o_wb_stb}
            !== {1'b1, 32'hDEADBEEF, 3'b010}) begin
            n_err++;
            $display("FAIL m0rd_ack got=%h exp=%h",
                     {o_m0_ack, o_m0_dat, o_m1_ack, o_m1_stall, o_wb_stb},
                     {1'b1, 32'hDEADBEEF, 3'b010});
        end
        step();
        wb_ack = 1'b0; m0_cyc = 1'b0;
        settle();
        n_cmp++;
        if ({o_wb_cyc, o_busy, o_m1_stall} !== 3'b011) begin
            n_err++;
            $display("FAIL m0rd_release got=%b exp=011", {o_wb_cyc, o_busy, o_m1_stall});
        end
        step(); settle();
        n_cmp++;
        if ({o_busy, o_m0_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL m0rd_idle got=%b exp=01", {o_busy, o_m0_stall});
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_priority();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h300; m0_sel = 4'h3;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_adr = 32'h200; m1_sel = 4'hF;
        m1_we  = 1'b1; m1_dat = 32'h12345678;
        settle();
        n_cmp++;
        if ({o_m0_stall, o_m1_stall} !== 2'b11) begin
            n_err++;
            $display("FAIL prio_idle_stall got=%b exp=11", {o_m0_stall, o_m1_stall});
        end
        step(); settle();
        n_cmp++;
        if ({o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb, o_wb_cyc, o_m0_stall, o_m1_stall}
            !== {32'h200, 32'h12345678, 4'hF, 5'b11110}) begin
            n_err++;
            $display("FAIL prio_m1_write got=%h exp=%h",
                     {o_wb_adr, o_wb_dat, o_wb_sel, o_wb_we, o_wb_stb, o_wb_cyc, o_m0_stall, o_m1_stall},
                     {32'h200, 32'h12345678, 4'hF, 5'b11110});
        end
        step();
        m1_stb = 1'b0; wb_ack = 1'b1;
        settle();
        n_cmp++;
        if ({o_m1_ack, o_m0_ack} !== 2'b10) begin
            n_err++;
            $display("FAIL prio_m1_ack got=%b exp=10", {o_m1_ack, o_m0_ack});
        end
        step();
        wb_ack = 1'b0; m1_cyc = 1'b0; m1_we = 1'b0;
        settle();
        step(); settle();
        n_cmp++;
        if ({o_busy, o_m0_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL prio_idle_gap got=%b exp=01", {o_busy, o_m0_stall});
        end
        step(); settle();
        n_cmp++;
        if ({o_wb_adr, o_wb_dat, o_wb_we, o_m0_stall, o_m1_stall}
            !== {32'h300, 32'h0, 3'b001}) begin
            n_err++;
            $display("FAIL prio_m0_after got=%h exp=%h",
                     {o_wb_adr, o_wb_dat, o_wb_we, o_m0_stall, o_m1_stall},
                     {32'h300, 32'h0, 3'b001});
        end
        step();
        m0_stb = 1'b0; wb_ack = 1'b1;
        step();
        wb_ack = 1'b0; m0_cyc = 1'b0;
        step(); step();
    endtask

    // ------------------------------------------------------------------
    // Last grant before this test was m0.
    task automatic test_ties();
        logic [2:0] exp_m1;
`ifdef ARB_ROUND_ROBIN_EN
        exp_m1 = 3'b101;
`else
        exp_m1 = 3'b111;
`endif
        for (int i = 0; i < 3; i++) begin
            m0_cyc = 1'b1; m1_cyc = 1'b1;
            step(); settle();
            n_cmp++;
            if ({o_m0_stall, o_m1_stall} !== (exp_m1[i] ? 2'b10 : 2'b01)) begin
                n_err++;
                $display("FAIL tie_grant_%0d got=%b exp=%b", i,
                         {o_m0_stall, o_m1_stall}, (exp_m1[i] ? 2'b10 : 2'b01));
            end
            m0_cyc = 1'b0; m1_cyc = 1'b0;
            step();
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_abort_drain();
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h500;
        step(); step(); step();
        step();
        m0_stb = 1'b0; wb_ack = 1'b1; wb_dat_i = 32'h0A0A0A0A;
        settle();
        n_cmp++;
        if (o_m0_ack !== 1'b1) begin
            n_err++;
            $display("FAIL abort_first_ack got=%b exp=1", o_m0_ack);
        end
        step();
        wb_ack = 1'b0; m0_cyc = 1'b0; m1_cyc = 1'b1; m1_adr = 32'h600;
        step();
        wb_ack = 1'b1;
        settle();
        n_cmp++;
        if ({o_wb_cyc, o_wb_stb, o_busy, o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack}
            !== 7'b1011100) begin
            n_err++;
            $display("FAIL abort_drain_1 got=%b exp=1011100",
                     {o_wb_cyc, o_wb_stb, o_busy, o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack});
        end
        step(); settle();
        n_cmp++;
        if ({o_busy, o_m0_ack, o_m1_ack, o_wb_cyc} !== 4'b1001) begin
            n_err++;
            $display("FAIL abort_drain_2 got=%b exp=1001",
                     {o_busy, o_m0_ack, o_m1_ack, o_wb_cyc});
        end
        step();
        wb_ack = 1'b0;
        settle();
        n_cmp++;
        if ({o_busy, o_m1_stall} !== 2'b01) begin
            n_err++;
            $display("FAIL abort_idle got=%b exp=01", {o_busy, o_m1_stall});
        end
        step(); settle();
        n_cmp++;
        if ({o_m1_stall, o_wb_adr} !== {1'b0, 32'h600}) begin
            n_err++;
            $display("FAIL abort_m1_grant got=%h exp=%h",
                     {o_m1_stall, o_wb_adr}, {1'b0, 32'h600});
        end
        m1_cyc = 1'b0;
        step(); step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_saturation();
        int acc_sat;
        int acc_main;
        acc_sat = 0; acc_main = 0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        m0_cyc = 1'b1; m0_stb = 1'b1; m0_adr = 32'h700; wb_stall = 1'b0;
        for (int k = 0; k < 8; k++) begin
            step(); settle();
            if (s_wb_stb && !wb_stall) acc_sat++;
            if (o_wb_stb && !wb_stall) acc_main++;
        end
        n_cmp++;
        if (acc_sat != 3) begin
            n_err++;
            $display("FAIL sat_accepts_w2 got=%0d exp=3", acc_sat);
        end
        n_cmp++;
        if (acc_main != 7) begin
            n_err++;
            $display("FAIL sat_accepts_w3 got=%0d exp=7", acc_main);
        end
        n_cmp++;
        if ({s_m0_stall, s_wb_stb, s_wb_cyc, o_m0_stall, o_wb_stb} !== 5'b10110) begin
            n_err++;
            $display("FAIL sat_held got=%b exp=10110",
                     {s_m0_stall, s_wb_stb, s_wb_cyc, o_m0_stall, o_wb_stb});
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        step();
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_midcycle();
        logic [75:0] obs;
        m1_cyc = 1'b1; m1_stb = 1'b1; m1_we = 1'b1;
        m1_adr = 32'h400; m1_dat = 32'hCAFEF00D; m1_sel = 4'hC;
        step(); step(); step();
        m1_stb = 1'b0;
        settle();
        n_cmp++;
        if ({o_busy, o_m1_stall, o_wb_cyc, o_wb_we} !== 4'b1011) begin
            n_err++;
            $display("FAIL rstmid_pre got=%b exp=1011",
                     {o_busy, o_m1_stall, o_wb_cyc, o_wb_we});
        end
        rst_n = 1'b0;
        #1;
        obs = {o_wb_cyc, o_wb_stb, o_wb_we, o_wb_adr, o_wb_sel, o_wb_dat,
               o_m0_stall, o_m1_stall, o_m0_ack, o_m1_ack, o_busy};
        n_cmp++;
        if (obs !== {3'b000, 32'h0, 4'h0, 32'h0, 2'b11, 3'b000}) begin
            n_err++;
            $display("FAIL rstmid_async got=%h exp=%h", obs,
                     {3'b000, 32'h0, 4'h0, 32'h0, 2'b11, 3'b000});
        end
        m1_cyc = 1'b0; m1_we = 1'b0;
        step();
        rst_n = 1'b1; wb_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            settle();
            n_cmp++;
            if ({o_m0_ack, o_m1_ack, o_busy, s_m0_ack, s_m1_ack} !== 5'b00000) begin
                n_err++;
                $display("FAIL rstmid_late_ack_%0d got=%b exp=00000", i,
                         {o_m0_ack, o_m1_ack, o_busy, s_m0_ack, s_m1_ack});
            end
            step();
        end
        wb_ack = 1'b0; m0_cyc = 1'b1; m0_stb = 1'b1;
        step(); settle();
        n_cmp++;
        if ({o_m0_stall, s_m0_stall, o_wb_stb, s_wb_stb} !== 4'b0011) begin
            n_err++;
            $display("FAIL rstmid_cnt_zero got=%b exp=0011",
                     {o_m0_stall, s_m0_stall, o_wb_stb, s_wb_stb});
        end
        m0_cyc = 1'b0; m0_stb = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_m0_read();
        test_priority();
        test_ties();
        test_abort_drain();
        test_saturation();
        test_reset_midcycle();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
